// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the ciphertext output path.
package aes_pkg;

  localparam int unsigned AES_BLK_W         = 128;
  localparam int unsigned AES_WORD_W        = 32;
  localparam int unsigned AES_WORDS_PER_BLK = 4;

  // Bit 0 is the MSB: the first ciphertext byte occupies bits [0:7].
  typedef logic [0:AES_BLK_W-1]  aes_blk_t;
  typedef logic [0:AES_WORD_W-1] aes_word_t;
  typedef logic [1:0]            word_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_e;

  localparam word_idx_t LAST_WORD_IDX = word_idx_t'(AES_WORDS_PER_BLK - 1);

  function automatic aes_word_t blk_word(input aes_blk_t blk, input word_idx_t idx);
    return blk[32'(idx) * AES_WORD_W +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit register FIFO; head entry is presented combinationally.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  aes_blk_t                     wr_data_i,
  input  logic                         rd_en_i,
  output aes_blk_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  aes_blk_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en_i && !rd_en_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_en_i && rd_en_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/aes_ct_out_buffer.sv
// Ciphertext output buffer: queues 128-bit blocks and streams them as four
// 32-bit words over a valid/ready handshake.
module aes_ct_out_buffer
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done_in,
  input  logic [0:AES_BLK_W-1]         ct_in,
  output logic                         in_ready,
  output logic                         overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:AES_WORD_W-1]        out_word,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  out_state_e state_q, state_d;
  word_idx_t  widx_q, widx_d;
  logic       ovf_q, ovf_d;

  logic       fifo_full, fifo_empty;
  logic       wr_en, rd_en;
  aes_blk_t   head_blk;

  assign wr_en = done_in && !fifo_full;
  assign rd_en = (state_q == SEND) && out_ready && (widx_q == LAST_WORD_IDX);

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (ct_in),
    .rd_en_i   (rd_en),
    .head_o    (head_blk),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Serializer next state; IDLE watches the write so word 0 appears next cycle.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ovf_d   = ovf_q | (done_in & fifo_full);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || wr_en) state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (widx_q == LAST_WORD_IDX) begin
            widx_d = '0;
            if ((count == CNT_W'(1)) && !wr_en) state_d = IDLE;
          end else begin
            widx_d = widx_q + word_idx_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      widx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign overflow  = ovf_q;
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (widx_q == LAST_WORD_IDX);
  assign out_word  = out_valid ? blk_word(head_blk, widx_q) : '0;

endmodule

// File: tb/tb_aes_ct_out_buffer.sv
// Bench for aes_ct_out_buffer: queue-based reference model plus directed vectors.
module tb_aes_ct_out_buffer;

  localparam int DEPTH = 4;
  localparam logic [127:0] K = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst, done_in, out_ready;
  logic [127:0] ct_in;
  logic         in_ready, overflow, out_valid, out_last;
  logic [31:0]  out_word;
  logic [2:0]   count;

  always #5 clk = ~clk;

  aes_ct_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .ct_in     (ct_in),
    .in_ready  (in_ready),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .count     (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] mq[$];
  int           mw = 0;
  bit           movf = 1'b0;
  logic [31:0]  acc[$];
  bit           chk_en = 1'b0;
  int           m_sz;
  bit           m_hs;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b, input int w);
    return 32'(b >> (96 - 32 * w));
  endfunction

  function automatic logic [127:0] mkblk(input int j);
    return {8'hA0, 24'(j), 8'hA1, 24'(j), 8'hA2, 24'(j), 8'hA3, 24'(j)};
  endfunction

  // Reference model: a block queue, a word cursor into its head, a sticky drop flag.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mw   = 0;
      movf = 1'b0;
    end else begin
      m_sz = mq.size();
      m_hs = (m_sz > 0) && out_ready;
      if (out_valid && out_ready) acc.push_back(out_word);
      if (m_hs) begin
        if (mw == 3) begin
          void'(mq.pop_front());
          mw = 0;
        end else begin
          mw++;
        end
      end
      if (done_in) begin
        if (m_sz < DEPTH) mq.push_back(ct_in);
        else movf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",    out_valid, mq.size() > 0);
      chk("count",    count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("overflow", overflow, movf);
      chk("last",     out_last, (mq.size() > 0) && (mw == 3));
      if (mq.size() > 0) chk("word", out_word, word_of(mq[0], mw));
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 5000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          nxt;
    bit          rs[5];
    logic [31:0] t1w[4];
    rs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t1w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

    rst = 1'b1; done_in = 1'b0; out_ready = 1'b0; ct_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid",    out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count",    count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_last",     out_last, 0);
    chk("rst_word",     out_word, 0);

    // Single block, consumer always ready
    rst = 1'b0; out_ready = 1'b1; done_in = 1'b1; ct_in = K;
    @(negedge clk); done_in = 1'b0;
    chk("t1_w0", out_word, 32'h69c4e0d8); chk("t1_cnt1", count, 1); chk("t1_last0", out_last, 0);
    @(negedge clk); chk("t1_w1", out_word, 32'h6a7b0430);
    @(negedge clk); chk("t1_w2", out_word, 32'hd8cdb780);
    @(negedge clk); chk("t1_w3", out_word, 32'h70b4c55a); chk("t1_last3", out_last, 1);
    @(negedge clk); chk("t1_idle", out_valid, 0); chk("t1_cnt0", count, 0);

    // Backpressure
    out_ready = 1'b0; done_in = 1'b1; ct_in = K;
    @(negedge clk); done_in = 1'b0;
    acc.delete();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_word", out_word, 32'h69c4e0d8);
      chk("t2_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      out_ready = rs[i];
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("t2_nwords", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) chk("t2_order", acc[i], t1w[i]);
    chk("t2_empty", count, 0);

    // Fill to DEPTH, then overflow
    acc.delete();
    for (int j = 1; j <= 5; j++) begin
      done_in = 1'b1; ct_in = 128'(j);
      @(negedge clk);
      if (j == 4) begin
        chk("t3_cnt4", count, 4);
        chk("t3_full", in_ready, 0);
      end
    end
    done_in = 1'b0;
    chk("t3_overflow", overflow, 1);
    chk("t3_cnt_keep", count, 4);
    out_ready = 1'b1;
    repeat (16) @(negedge clk);
    out_ready = 1'b0;
    chk("t3_nwords", acc.size(), 16);
    for (int i = 0; i < 16 && i < acc.size(); i++)
      chk("t3_word", acc[i], ((i % 4) == 3) ? 32'(i / 4 + 1) : 32'h0);
    chk("t3_empty", count, 0);

    // Write coinciding with the word-3 pop, queue held at two blocks
    acc.delete();
    for (int j = 0; j < 2; j++) begin
      done_in = 1'b1; ct_in = mkblk(j);
      @(negedge clk);
    end
    done_in = 1'b0; out_ready = 1'b1;
    nxt = 2;
    for (int j = 0; j < 7; j++) begin
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        if (out_last) found = 1'b1;
        else @(negedge clk);
      end
      chk("t4_last_seen", found, 1);
      done_in = 1'b1; ct_in = mkblk(nxt); nxt++;
      @(negedge clk); done_in = 1'b0;
      chk("t4_cnt2", count, 2);
      chk("t4_nobubble", out_valid, 1);
      chk("t4_next_w0", out_word, {8'hA0, 24'(j + 1)});
    end
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    chk("t4_nwords", acc.size(), 36);
    for (int i = 0; i < 36 && i < acc.size(); i++)
      chk("t4_word", acc[i], {8'(8'hA0 + (i % 4)), 24'(i / 4)});
    chk("t4_empty", count, 0);

    // Reset in the middle of a block
    for (int j = 32; j < 34; j++) begin
      done_in = 1'b1; ct_in = mkblk(j);
      @(negedge clk);
    end
    done_in = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_w1", out_word, {8'hA1, 24'(32)});
    rst = 1'b1;
    @(negedge clk);
    chk("t5_valid0", out_valid, 0);
    chk("t5_cnt0", count, 0);
    chk("t5_ovf0", overflow, 0);
    chk("t5_in_ready", in_ready, 1);
    rst = 1'b0; done_in = 1'b1; ct_in = K;
    @(negedge clk); done_in = 1'b0;
    chk("t5_fresh_w0", out_word, 32'h69c4e0d8);
    chk("t5_cnt1", count, 1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
